// File: rtl/buffer_packer.sv
// Drain stage for the buffer FIFO: pops words and packs PACK of them into one wide beat
// presented on a valid/ready handshake, with flush to close a partial beat early.
module buffer_packer #(
    parameter int unsigned bit_width = 16,
    parameter int unsigned PACK      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        empty,
    input  logic [bit_width-1:0]        data_in,
    output logic                        consume,
    input  logic                        flush,
    output logic [bit_width*PACK-1:0]   out_data,
    output logic [$clog2(PACK):0]       out_cnt,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int unsigned CW = $clog2(PACK) + 1;
    localparam int unsigned AW = bit_width * PACK;
    localparam logic [CW-1:0] LastLane = CW'(PACK - 1);

    typedef enum logic {StFill, StHold} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   filled;
    logic [AW-1:0]   acc_q, acc_d, acc_cap;
    logic [AW-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic            can_step;
    logic            close;

    // The accumulator may advance in FILL, or in HOLD when the held beat leaves this edge.
    assign can_step = (state_q == StFill) | out_ready;
    assign consume  = rst & ~empty & can_step;
    assign filled   = cnt_q + CW'(consume);
    assign close    = can_step & ((consume & (cnt_q == LastLane)) | (flush & (filled != '0)));

    always_comb begin
        acc_cap = acc_q;
        for (int i = 0; i < int'(PACK); i++) begin
            if (consume && (cnt_q == CW'(i))) begin
                acc_cap[i*bit_width +: bit_width] = data_in;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_cnt_d  = out_cnt_q;
        if (close) begin
            // Accumulator is cleared after every close, so unfilled lanes are already zero.
            state_d    = StHold;
            cnt_d      = '0;
            acc_d      = '0;
            out_data_d = acc_cap;
            out_cnt_d  = filled;
        end else begin
            cnt_d = filled;
            acc_d = acc_cap;
            if (state_q == StHold && out_ready) begin
                state_d = StFill;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StFill;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign out_valid = (state_q == StHold);

endmodule
